// File: rtl/code_patch_pkg.sv
// code_patch_pkg: shared types and default widths for the code-patch
// sequencer.
//   cps_state_e : sequencer FSM states
//   cp_entry_t  : one patch-table entry {valid, addr, data}
package code_patch_pkg;

  localparam int CP_ADDR_W    = 13;
  localparam int CP_DATA_W    = 22;
  localparam int CP_HIT_CNT_W = 16;

  typedef enum logic [1:0] {
    CPS_IDLE   = 2'd0,
    CPS_LOOKUP = 2'd1,
    CPS_RESP   = 2'd2,
    CPS_CLEAR  = 2'd3
  } cps_state_e;

  typedef struct packed {
    logic                 valid;
    logic [CP_ADDR_W-1:0] addr;
    logic [CP_DATA_W-1:0] data;
  } cp_entry_t;

endpackage

// File: rtl/code_patch_match.sv
// code_patch_match: combinational priority matcher over the patch table.
//   entries : packed array of table entries
//   addr    : address to look up
//   hit     : some valid entry matches addr
//   idx     : lowest matching index (0 on miss)
//   data    : patch word of that entry (0 on miss)
module code_patch_match
  import code_patch_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  cp_entry_t [NUM_ENTRIES-1:0] entries,
  input  logic [CP_ADDR_W-1:0]        addr,
  output logic                        hit,
  output logic [IDX_W-1:0]            idx,
  output logic [CP_DATA_W-1:0]        data
);

  // Scan from the top down so the lowest matching index is the last writer.
  always_comb begin
    hit  = 1'b0;
    idx  = '0;
    data = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (entries[i].valid && (entries[i].addr == addr)) begin
        hit  = 1'b1;
        idx  = IDX_W'(i);
        data = entries[i].data;
      end
    end
  end

endmodule

// File: rtl/code_patch_seq.sv
// code_patch_seq: sequencer and config front-end for the code-patch datapath.
// Holds the patch table, serves one read request at a time through a
// ready/valid handshake, counts hits and sequences a one-entry-per-cycle
// table clear.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | ready for a request or a clear
// LOOKUP | registered address compared against the table
// RESP   | response registered onto the outputs
// CLEAR  | invalidating entries 0..N-1, one per cycle
//
// Ports:
//   clk_i, rst_ni                    clock, async active-low reset
//   cfg_pat_gen_i                    global patch enable (sampled on accept)
//   cfg_we_i/idx/addr/data           entry write
//   cfg_clr_i                        invalidate the whole table
//   cfg_err_o                        pulse: config write dropped
//   si_read_i/si_addr_i/si_ready_o   request handshake
//   rsp_valid_o/nopg_o/patch_data_o/hit_idx_o  registered response
//   hit_cnt_o                        saturating hit counter
//   busy_o                           FSM not in IDLE
// ADDR_W/DATA_W must equal the package widths, which size cp_entry_t.
module code_patch_seq
  import code_patch_pkg::*;
#(
  parameter int NUM_ENTRIES = 3,
  parameter int ADDR_W      = CP_ADDR_W,
  parameter int DATA_W      = CP_DATA_W,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cfg_pat_gen_i,
  input  logic                    cfg_we_i,
  input  logic [IDX_W-1:0]        cfg_idx_i,
  input  logic [ADDR_W-1:0]       cfg_addr_i,
  input  logic [DATA_W-1:0]       cfg_data_i,
  input  logic                    cfg_clr_i,
  output logic                    cfg_err_o,
  input  logic                    si_read_i,
  input  logic [ADDR_W-1:0]       si_addr_i,
  output logic                    si_ready_o,
  output logic                    rsp_valid_o,
  output logic                    nopg_o,
  output logic [DATA_W-1:0]       patch_data_o,
  output logic [IDX_W-1:0]        hit_idx_o,
  output logic [CP_HIT_CNT_W-1:0] hit_cnt_o,
  output logic                    busy_o
);

  cps_state_e                  state, state_nx;
  cp_entry_t [NUM_ENTRIES-1:0] entries;
  logic [ADDR_W-1:0]           addr_q;
  logic                        en_q;
  logic                        hit_q;
  logic [IDX_W-1:0]            idx_q;
  logic [DATA_W-1:0]           data_q;
  logic                        clr_pend;
  logic [IDX_W-1:0]            clr_left;
  logic [IDX_W-1:0]            clr_idx;

  logic                        m_hit;
  logic [IDX_W-1:0]            m_idx;
  logic [DATA_W-1:0]           m_data;

  logic clr_now, accept, idx_ok, wr_ok, resp_hit;

  code_patch_match #(
    .NUM_ENTRIES(NUM_ENTRIES),
    .IDX_W      (IDX_W)
  ) u_match (
    .entries(entries),
    .addr   (addr_q),
    .hit    (m_hit),
    .idx    (m_idx),
    .data   (m_data)
  );

  assign clr_now  = cfg_clr_i | clr_pend;
  assign accept   = (state == CPS_IDLE) && !clr_now && si_read_i && si_ready_o;
  assign idx_ok   = {1'b0, cfg_idx_i} < (IDX_W + 1)'(NUM_ENTRIES);
  // A write colliding with a clear request in IDLE loses to the clear.
  assign wr_ok    = cfg_we_i && idx_ok && (state != CPS_CLEAR) &&
                    !((state == CPS_IDLE) && cfg_clr_i);
  assign resp_hit = (state == CPS_RESP) && hit_q && en_q;
  // Down-counter drives the sweep, so the entry index counts up from 0.
  assign clr_idx  = IDX_W'(NUM_ENTRIES - 1) - clr_left;

  always_comb begin
    state_nx = state;
    case (state)
      CPS_IDLE:   if (clr_now) state_nx = CPS_CLEAR;
                  else if (accept) state_nx = CPS_LOOKUP;
      CPS_LOOKUP: state_nx = CPS_RESP;
      CPS_RESP:   state_nx = clr_now ? CPS_CLEAR : CPS_IDLE;
      CPS_CLEAR:  if (clr_left == '0) state_nx = CPS_IDLE;
      default:    state_nx = CPS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= CPS_IDLE;
      entries      <= '0;
      addr_q       <= '0;
      en_q         <= 1'b0;
      hit_q        <= 1'b0;
      idx_q        <= '0;
      data_q       <= '0;
      clr_pend     <= 1'b0;
      clr_left     <= '0;
      si_ready_o   <= 1'b1;
      busy_o       <= 1'b0;
      rsp_valid_o  <= 1'b0;
      nopg_o       <= 1'b0;
      patch_data_o <= '0;
      hit_idx_o    <= '0;
      hit_cnt_o    <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      state        <= state_nx;
      si_ready_o   <= (state_nx == CPS_IDLE);
      busy_o       <= (state_nx != CPS_IDLE);
      rsp_valid_o  <= (state == CPS_RESP);
      nopg_o       <= resp_hit;
      patch_data_o <= resp_hit ? data_q : '0;
      hit_idx_o    <= resp_hit ? idx_q : '0;
      cfg_err_o    <= cfg_we_i && !wr_ok;

      if (resp_hit && (hit_cnt_o != '1)) hit_cnt_o <= hit_cnt_o + 16'd1;

      if (accept) begin
        addr_q <= si_addr_i;
        en_q   <= cfg_pat_gen_i;
      end

      // Compare uses pre-write table contents; writes land on this same edge.
      if (state == CPS_LOOKUP) begin
        hit_q  <= m_hit;
        idx_q  <= m_idx;
        data_q <= m_data;
      end

      if (state_nx == CPS_CLEAR) clr_pend <= 1'b0;
      else if (((state == CPS_LOOKUP) || (state == CPS_RESP)) && cfg_clr_i) clr_pend <= 1'b1;

      if ((state_nx == CPS_CLEAR) && (state != CPS_CLEAR)) clr_left <= IDX_W'(NUM_ENTRIES - 1);
      else if (state == CPS_CLEAR) clr_left <= clr_left - 1'b1;

      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if ((state == CPS_CLEAR) && (clr_idx == IDX_W'(i))) begin
          entries[i].valid <= 1'b0;
        end else if (wr_ok && (cfg_idx_i == IDX_W'(i))) begin
          entries[i] <= '{valid: 1'b1, addr: cfg_addr_i, data: cfg_data_i};
        end
      end
    end
  end

endmodule

// File: tb/tb_code_patch_seq.sv
// tb_code_patch_seq: directed and randomized checks of code_patch_seq against
// a table-level reference model (arrays of valid/addr/data plus a hit count).
module tb_code_patch_seq;

  localparam int N  = 3;
  localparam int AW = 13;
  localparam int DW = 22;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pat_gen = 1'b0;
  logic          we = 1'b0;
  logic [IW-1:0] idx = '0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          clr = 1'b0;
  logic          cfg_err;
  logic          si_read = 1'b0;
  logic [AW-1:0] si_addr = '0;
  logic          si_ready;
  logic          rsp_valid;
  logic          nopg;
  logic [DW-1:0] patch_data;
  logic [IW-1:0] hit_idx;
  logic [15:0]   hit_cnt;
  logic          busy;

  int passed = 0;
  int total  = 0;

  bit          m_valid [N];
  logic [AW-1:0] m_addr [N];
  logic [DW-1:0] m_data [N];
  int          m_cnt = 0;

  logic [AW-1:0] pool [4] = '{13'h0A5, 13'h100, 13'h101, 13'h1FFF};

  always #5 clk = ~clk;

  code_patch_seq dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_pat_gen_i(pat_gen),
    .cfg_we_i     (we),
    .cfg_idx_i    (idx),
    .cfg_addr_i   (waddr),
    .cfg_data_i   (wdata),
    .cfg_clr_i    (clr),
    .cfg_err_o    (cfg_err),
    .si_read_i    (si_read),
    .si_addr_i    (si_addr),
    .si_ready_o   (si_ready),
    .rsp_valid_o  (rsp_valid),
    .nopg_o       (nopg),
    .patch_data_o (patch_data),
    .hit_idx_o    (hit_idx),
    .hit_cnt_o    (hit_cnt),
    .busy_o       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endfunction

  task automatic cfg_write(input int widx, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit bad;
    bad = (widx >= N);
    @(negedge clk);
    we = 1'b1; idx = IW'(widx); waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    check("cfg_err_wr", {31'd0, cfg_err}, {31'd0, bad});
    if (!bad) begin
      m_valid[widx] = 1'b1; m_addr[widx] = a; m_data[widx] = d;
    end
    @(negedge clk);
    check("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
  endtask

  // mode 0: plain clear; 1: write issued during CLEAR; 2: write together with clear
  task automatic do_clear(input int mode);
    @(negedge clk);
    clr = 1'b1;
    if (mode == 2) begin we = 1'b1; idx = 2'd0; waddr = pool[0]; wdata = 22'h3ABCD; end
    @(negedge clk);
    clr = 1'b0; we = 1'b0;
    if (mode == 1) begin we = 1'b1; idx = 2'd1; waddr = pool[0]; wdata = 22'h15555; end
    check("clr_busy0", {31'd0, busy}, 32'd1);
    check("clr_ready0", {31'd0, si_ready}, 32'd0);
    check("clr_err0", {31'd0, cfg_err}, {31'd0, mode == 2});
    @(negedge clk);
    we = 1'b0;
    check("clr_busy1", {31'd0, busy}, 32'd1);
    check("clr_err1", {31'd0, cfg_err}, {31'd0, mode == 1});
    @(negedge clk);
    check("clr_busy2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("clr_busy_done", {31'd0, busy}, 32'd0);
    check("clr_ready_done", {31'd0, si_ready}, 32'd1);
    model_clear();
  endtask

  task automatic read_req(input logic [AW-1:0] a, input bit en, input bit en_after, input bit clr_lookup);
    bit h, exp_hit;
    int hix;
    logic [DW-1:0] hd;
    h = 1'b0; hix = 0; hd = '0;
    for (int i = 0; i < N; i++) begin
      if (!h && m_valid[i] && m_addr[i] == a) begin h = 1'b1; hix = i; hd = m_data[i]; end
    end
    exp_hit = h && en;
    if (exp_hit && m_cnt < 16'hFFFF) m_cnt++;
    @(negedge clk);
    check("rd_ready", {31'd0, si_ready}, 32'd1);
    si_read = 1'b1; si_addr = a; pat_gen = en;
    @(negedge clk);
    si_read = 1'b0; pat_gen = en_after; clr = clr_lookup;
    check("rd_lookup_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rd_lookup_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    clr = 1'b0;
    check("rd_resp_rsp", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    check("rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("nopg", {31'd0, nopg}, {31'd0, exp_hit});
    check("patch_data", {10'd0, patch_data}, exp_hit ? {10'd0, hd} : 32'd0);
    check("hit_idx", {30'd0, hit_idx}, exp_hit ? 32'(hix) : 32'd0);
    check("hit_cnt", {16'd0, hit_cnt}, 32'(m_cnt));
    check("rsp_busy", {31'd0, busy}, {31'd0, clr_lookup});
    if (clr_lookup) begin
      model_clear();
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        check("pend_clr_busy", {31'd0, busy}, 32'd1);
        check("pend_clr_ready", {31'd0, si_ready}, 32'd0);
      end
    end
    @(negedge clk);
    check("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_ready", {31'd0, si_ready}, 32'd1);
    check("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    // Reset state
    check("rst_ready", {31'd0, si_ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rst_nopg", {31'd0, nopg}, 32'd0);
    check("rst_data", {10'd0, patch_data}, 32'd0);
    check("rst_cnt", {16'd0, hit_cnt}, 32'd0);
    check("rst_err", {31'd0, cfg_err}, 32'd0);
    rst_n = 1'b1;

    // Basic hit on entry 1
    cfg_write(1, 13'h0A5, 22'h12345);
    read_req(13'h0A5, 1'b1, 1'b1, 1'b0);

    // Duplicate addresses: lowest index wins; adjacent address misses
    cfg_write(0, 13'h100, 22'h0AAAA);
    cfg_write(2, 13'h100, 22'h05555);
    read_req(13'h100, 1'b1, 1'b1, 1'b0);
    read_req(13'h101, 1'b1, 1'b1, 1'b0);

    // Enable low at acceptance, raised afterwards: no hit
    read_req(13'h0A5, 1'b0, 1'b1, 1'b0);

    // Clear during LOOKUP: this response still hits, next one misses
    read_req(13'h0A5, 1'b1, 1'b1, 1'b1);
    read_req(13'h0A5, 1'b1, 1'b1, 1'b0);

    // Rejected writes
    cfg_write(1, 13'h0A5, 22'h00777);
    cfg_write(3, 13'h0A5, 22'h3FFFF);
    read_req(13'h0A5, 1'b1, 1'b1, 1'b0);
    do_clear(1);
    read_req(13'h0A5, 1'b1, 1'b1, 1'b0);
    do_clear(2);
    read_req(13'h0A5, 1'b1, 1'b1, 1'b0);

    // Counter saturation
    cfg_write(2, 13'h1FFF, 22'h2F0F0);
    @(negedge clk);
    force dut.hit_cnt_o = 16'hFFFE;
    @(negedge clk);
    release dut.hit_cnt_o;
    m_cnt = 16'hFFFE;
    @(negedge clk);
    check("cnt_preload", {16'd0, hit_cnt}, 32'h0000FFFE);
    read_req(13'h1FFF, 1'b1, 1'b1, 1'b0);
    read_req(13'h1FFF, 1'b1, 1'b1, 1'b0);
    read_req(13'h1FFF, 1'b1, 1'b1, 1'b0);

    // Reset while in RESP
    @(negedge clk);
    si_read = 1'b1; si_addr = 13'h1FFF; pat_gen = 1'b1;
    @(negedge clk);
    si_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_rsp", {31'd0, rsp_valid}, 32'd0);
    check("rstmid_ready", {31'd0, si_ready}, 32'd1);
    check("rstmid_cnt", {16'd0, hit_cnt}, 32'd0);
    @(negedge clk);
    check("rstmid_rsp_hold", {31'd0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    model_clear();
    m_cnt = 0;
    read_req(13'h1FFF, 1'b1, 1'b1, 1'b0);

    // Randomized traffic against the model
    for (int k = 0; k < 60; k++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op <= 3) begin
        cfg_write($urandom_range(0, 3), pool[$urandom_range(0, 3)], DW'($urandom));
      end else if (op <= 7) begin
        read_req(pool[$urandom_range(0, 3)], 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'b0);
      end else if (op == 8) begin
        read_req(pool[$urandom_range(0, 3)], 1'b1, 1'b1, 1'b1);
      end else begin
        do_clear($urandom_range(0, 2));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
